// File: rtl/fft_result_collector.sv
// Collects one frame of N complex FFT results (optionally bit-reverse addressed)
// and drains it in natural order over a valid/ready stream.
module fft_result_collector #(
  parameter int unsigned N      = 64,
  parameter int unsigned LOG2N  = 6,
  parameter int unsigned W      = 16,
  parameter int unsigned BITREV = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [W-1:0]     in_real,
  input  logic [W-1:0]     in_imag,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_real,
  output logic [W-1:0]     out_imag,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             finished,
  output logic             overrun
);

  localparam int unsigned CW = LOG2N + 1;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
  } sample_t;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    rd_cnt;
  sample_t          mem [N];
  sample_t          rd_data;
  logic [LOG2N-1:0] wr_addr;
  logic             start_ok;
  logic             wr_en;
  logic             xfer;
  logic             last_xfer;
  logic             load;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < int'(LOG2N); i++) r[i] = a[int'(LOG2N) - 1 - i];
    return r;
  endfunction

  assign wr_addr = (BITREV != 0) ? bitrev(cnt[LOG2N-1:0]) : cnt[LOG2N-1:0];
  assign rd_data = mem[rd_cnt[LOG2N-1:0]];

  // Next-state and per-cycle strobes
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    wr_en     = 1'b0;
    xfer      = out_valid && out_ready;
    last_xfer = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (cnt == CW'(N - 1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && (out_index == LOG2N'(N - 1))) begin
          last_xfer = 1'b1;
          state_nxt = DONE;
        end
        // First DRAIN cycle primes the output stage; afterwards refill on each transfer
        load = !out_valid || (xfer && !last_xfer);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sample buffer has no reset; every frame overwrites all N entries
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= '{re: in_real, im: in_imag};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_cnt    <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      finished  <= 1'b0;
      overrun   <= 1'b0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == CAPTURE);
      busy     <= (state_nxt == CAPTURE) || (state_nxt == DRAIN);
      finished <= (state_nxt == DONE);

      if (start_ok) cnt <= '0;
      else if (wr_en) cnt <= cnt + CW'(1);

      // A sample arriving with the arming start is still dropped and flagged
      if (start_ok) overrun <= in_valid;
      else if (in_valid && (state != CAPTURE)) overrun <= 1'b1;

      if (start_ok) begin
        rd_cnt <= '0;
      end else if (load) begin
        out_valid <= 1'b1;
        out_real  <= rd_data.re;
        out_imag  <= rd_data.im;
        out_index <= rd_cnt[LOG2N-1:0];
        out_last  <= (rd_cnt == CW'(N - 1));
        rd_cnt    <= rd_cnt + CW'(1);
      end else if (last_xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_result_collector.sv
// Bench for fft_result_collector: natural-order and bit-reversed instances
// share stimulus; a negedge monitor checks drained samples against queues.
module tb_fft_result_collector;

  localparam int unsigned N     = 64;
  localparam int unsigned LOG2N = 6;
  localparam int unsigned W     = 16;

  typedef struct {
    logic [W-1:0]     re;
    logic [W-1:0]     im;
    logic [LOG2N-1:0] idx;
  } exp_t;

  typedef struct {
    logic s;
    logic iv;
    logic rdy;
    logic bsy;
    logic fin;
    logic ovr;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic             in_valid;
  logic [W-1:0]     in_real;
  logic [W-1:0]     in_imag;
  logic             out_ready;
  logic             in_ready  [2];
  logic             out_valid [2];
  logic [W-1:0]     out_real  [2];
  logic [W-1:0]     out_imag  [2];
  logic [LOG2N-1:0] out_index [2];
  logic             out_last  [2];
  logic             busy      [2];
  logic             finished  [2];
  logic             overrun   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  fft_result_collector #(.N(N), .LOG2N(LOG2N), .W(W), .BITREV(0)) dut_nat (
    .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_real(in_real), .in_imag(in_imag), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_real(out_real[0]),
    .out_imag(out_imag[0]), .out_index(out_index[0]), .out_last(out_last[0]),
    .busy(busy[0]), .finished(finished[0]), .overrun(overrun[0])
  );

  fft_result_collector #(.N(N), .LOG2N(LOG2N), .W(W), .BITREV(1)) dut_rev (
    .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_real(in_real), .in_imag(in_imag), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_real(out_real[1]),
    .out_imag(out_imag[1]), .out_index(out_index[1]), .out_last(out_last[1]),
    .busy(busy[1]), .finished(finished[1]), .overrun(overrun[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LOG2N-1:0] br(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] y;
    y = {<<{x}};
    return y;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s_all_zero[%0d]", tag, d),
          {in_ready[d], out_valid[d], out_real[d], out_imag[d], out_index[d],
           out_last[d], busy[d], finished[d], overrun[d]}, 64'd0);
  endtask

  // Transfer monitor: scoreboard pop, out_last, hold-under-backpressure, DONE timing
  logic hold_v   [2];
  exp_t hold_s   [2];
  logic fin_pend [2];

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        hold_v[d]   = 1'b0;
        fin_pend[d] = 1'b0;
      end else begin
        if (fin_pend[d]) begin
          chk($sformatf("finished_after_last[%0d]", d), {finished[d], out_valid[d]}, 64'b10);
          fin_pend[d] = 1'b0;
        end
        if (hold_v[d])
          chk($sformatf("hold_stable[%0d]", d),
              {out_valid[d], out_real[d], out_imag[d], out_index[d]},
              {1'b1, hold_s[d].re, hold_s[d].im, hold_s[d].idx});
        hold_v[d] = 1'b0;
        if (out_valid[d]) begin
          if (out_ready) begin
            exp_t e;
            int   sz;
            sz = (d == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_output[%0d]: got index %0d expected no transfer", d, out_index[d]);
            end else begin
              e = (d == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("data[%0d] idx %0d", d, e.idx),
                  {out_real[d], out_imag[d], out_index[d]}, {e.re, e.im, e.idx});
              chk($sformatf("out_last[%0d] idx %0d", d, e.idx), out_last[d], e.idx == LOG2N'(N - 1));
              if (out_index[d] == LOG2N'(N - 1)) fin_pend[d] = 1'b1;
            end
          end else begin
            hold_v[d] = 1'b1;
            hold_s[d] = '{out_real[d], out_imag[d], out_index[d]};
          end
        end
      end
    end
  end

  task automatic run_frame(input bit do_start, input int kind, input bit gaps,
                           input bit bp, input bit start_in_drain);
    logic [W-1:0] cap_re [N];
    logic [W-1:0] cap_im [N];
    logic [3:0]   pat;
    int           cyc;
    pat = 4'b1001;
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
      chk("overrun_cleared_by_start", {overrun[0], overrun[1]}, 64'd0);
    end
    for (int d = 0; d < 2; d++)
      chk($sformatf("capture_flags[%0d]", d), {in_ready[d], busy[d], finished[d]}, 64'b110);
    for (int c = 0; c < int'(N); c++) begin
      if (gaps) begin
        int g = int'($urandom_range(0, 2));
        for (int j = 0; j < g; j++) begin
          in_valid = 1'b0;
          in_real  = W'($urandom);
          step();
        end
      end
      case (kind)
        0:       begin cap_re[c] = W'(c);          cap_im[c] = W'(-c);          end
        1:       begin cap_re[c] = W'($urandom);   cap_im[c] = W'($urandom);    end
        2:       begin cap_re[c] = 16'h7FFF;       cap_im[c] = 16'h8000;        end
        default: begin cap_re[c] = W'(c * 3 + 5);  cap_im[c] = ~W'(c);          end
      endcase
      in_valid = 1'b1;
      in_real  = cap_re[c];
      in_imag  = cap_im[c];
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      q0.push_back('{cap_re[k], cap_im[k], LOG2N'(k)});
      q1.push_back('{cap_re[br(LOG2N'(k))], cap_im[br(LOG2N'(k))], LOG2N'(k)});
    end
    out_ready = 1'b1;
    chk("drain_entry_valid_low", {out_valid[0], out_valid[1], busy[0], busy[1]}, 64'b0011);
    step();
    chk("first_out_valid", {out_valid[0], out_valid[1], out_index[0], out_index[1]}, 64'b11 << 12);
    cyc = 0;
    while (cyc < 600 && !finished[0]) begin
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      start     = start_in_drain && (cyc == 10);
      step();
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    for (int d = 0; d < 2; d++)
      chk($sformatf("frame_done_flags[%0d]", d),
          {finished[d], busy[d], in_ready[d], out_valid[d]}, 64'b1000);
    chk("scoreboard_drained", q0.size() + q1.size(), 64'd0);
  endtask

  vec_t tbl [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{s: 1'b0, iv: 1'b1, rdy: 1'b0, bsy: 1'b0, fin: 1'b0, ovr: 1'b1};
    tbl[1] = '{s: 1'b0, iv: 1'b0, rdy: 1'b0, bsy: 1'b0, fin: 1'b0, ovr: 1'b1};
    tbl[2] = '{s: 1'b1, iv: 1'b1, rdy: 1'b1, bsy: 1'b1, fin: 1'b0, ovr: 1'b1};
    tbl[3] = '{s: 1'b1, iv: 1'b0, rdy: 1'b1, bsy: 1'b1, fin: 1'b0, ovr: 1'b1};

    reset_n   = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    out_ready = 1'b0;
    step();
    step();
    check_zero("reset");
    reset_n = 1'b1;
    step();
    check_zero("idle_after_reset");

    // IDLE overrun, start+in_valid collision, start ignored in CAPTURE
    for (int r = 0; r < 4; r++) begin
      start    = tbl[r].s;
      in_valid = tbl[r].iv;
      in_real  = 16'hDEAD;
      in_imag  = 16'hBEEF;
      step();
      start    = 1'b0;
      in_valid = 1'b0;
      for (int d = 0; d < 2; d++)
        chk($sformatf("ctrl_row%0d[%0d]", r, d),
            {in_ready[d], busy[d], finished[d], overrun[d]},
            {tbl[r].rdy, tbl[r].bsy, tbl[r].fin, tbl[r].ovr});
    end

    run_frame(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("overrun_sticky", {overrun[0], overrun[1]}, 64'b11);

    run_frame(1'b1, 1, 1'b1, 1'b1, 1'b0);

    // in_valid in DONE flags overrun and leaves DONE untouched
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_real  = 16'h1234;
      in_imag  = 16'h5678;
      step();
    end
    in_valid = 1'b0;
    for (int d = 0; d < 2; d++)
      chk($sformatf("done_overrun[%0d]", d),
          {overrun[d], finished[d], busy[d], in_ready[d]}, 64'b1100);

    run_frame(1'b1, 3, 1'b0, 1'b0, 1'b1);
    run_frame(1'b1, 2, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of DRAIN with out_valid high
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < int'(N); c++) begin
      in_valid = 1'b1;
      in_real  = W'(c);
      in_imag  = W'(c);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 10 && !out_valid[0]; i++) step();
    chk("pre_reset_valid", {out_valid[0], out_valid[1]}, 64'b11);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset_drain");
    step();
    reset_n = 1'b1;
    step();
    check_zero("idle_after_mid_reset");

    run_frame(1'b1, 0, 1'b0, 1'b1, 1'b0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
